// File: rtl/basic_gate_unit_if.sv
// Valid/ready stream bundle for basic_gate_unit: operands in, registered gate results out.
// With BASIC_GATE_INV_EN defined, the inverted-gate results nand/nor/xnor are also carried.
interface basic_gate_unit_if #(
  parameter int unsigned WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] or_out;
  logic [WIDTH-1:0] xor_out;
  logic [WIDTH-1:0] not_out;
`ifdef BASIC_GATE_INV_EN
  logic [WIDTH-1:0] nand_out;
  logic [WIDTH-1:0] nor_out;
  logic [WIDTH-1:0] xnor_out;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, and_out, or_out, xor_out, not_out
`ifdef BASIC_GATE_INV_EN
    , nand_out, nor_out, xnor_out
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, and_out, or_out, xor_out, not_out
`ifdef BASIC_GATE_INV_EN
    , nand_out, nor_out, xnor_out
`endif
  );
endinterface

// File: rtl/basic_gate_unit.sv
// Registered bitwise AND/OR/XOR/NOT stage with a one-deep valid/ready output register.
// BASIC_GATE_INV_EN adds registered NAND/NOR/XNOR outputs under the same rules.
module basic_gate_unit #(
  parameter int unsigned WIDTH = 1
) (
  input logic              clk,
  input logic              rst,
  basic_gate_unit_if.slave bus
);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [WIDTH-1:0] and_q, or_q, xor_q, not_q;
`ifdef BASIC_GATE_INV_EN
  logic [WIDTH-1:0] nand_q, nor_q, xnor_q;
`endif

  // Ready is a function of the output register only, never of in_valid.
  assign bus.in_ready  = (state == S_EMPTY) || bus.out_ready;
  assign bus.out_valid = (state == S_FULL);
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (accept) state_nxt = S_FULL;
      S_FULL:  if (bus.out_ready && !accept) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      and_q  <= '0;
      or_q   <= '0;
      xor_q  <= '0;
      not_q  <= '0;
`ifdef BASIC_GATE_INV_EN
      nand_q <= '0;
      nor_q  <= '0;
      xnor_q <= '0;
`endif
    end else if (accept) begin
      and_q  <= bus.a & bus.b;
      or_q   <= bus.a | bus.b;
      xor_q  <= bus.a ^ bus.b;
      not_q  <= ~bus.a;
`ifdef BASIC_GATE_INV_EN
      nand_q <= ~(bus.a & bus.b);
      nor_q  <= ~(bus.a | bus.b);
      xnor_q <= ~(bus.a ^ bus.b);
`endif
    end
  end

  assign bus.and_out  = and_q;
  assign bus.or_out   = or_q;
  assign bus.xor_out  = xor_q;
  assign bus.not_out  = not_q;
`ifdef BASIC_GATE_INV_EN
  assign bus.nand_out = nand_q;
  assign bus.nor_out  = nor_q;
  assign bus.xnor_out = xnor_q;
`endif

endmodule

// File: tb/tb_basic_gate_unit.sv
// Directed-vector bench for basic_gate_unit at WIDTH=1 and WIDTH=8.
// Inverted-gate outputs are checked when BASIC_GATE_INV_EN is defined.
module tb_basic_gate_unit;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  basic_gate_unit_if #(.WIDTH(1)) bus1 ();
  basic_gate_unit_if #(.WIDTH(8)) bus8 ();

  basic_gate_unit #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  basic_gate_unit #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {and,or,xor,not} for (a,b) = 00,01,10,11.
  logic [3:0] tt_exp [4];
  logic [7:0] tp_a   [4];
  logic [7:0] tp_b   [4];
  logic [7:0] tp_and [4];
  logic [7:0] tp_or  [4];
  logic [7:0] tp_xor [4];
  logic [7:0] tp_not [4];

  initial begin
    tt_exp = '{4'b0001, 4'b0111, 4'b0110, 4'b1100};
    tp_a   = '{8'h01, 8'hAA, 8'h0F, 8'hC3};
    tp_b   = '{8'h03, 8'h55, 8'hFF, 8'h81};
    tp_and = '{8'h01, 8'h00, 8'h0F, 8'h81};
    tp_or  = '{8'h03, 8'hFF, 8'hFF, 8'hC3};
    tp_xor = '{8'h02, 8'hFF, 8'hF0, 8'h42};
    tp_not = '{8'hFE, 8'h55, 8'hF0, 8'h3C};

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
    tick();
    tick();

    check_val("rst_valid1", 32'(bus1.out_valid), 32'd0);
    check_val("rst_ready1", 32'(bus1.in_ready), 32'd1);
    check_val("rst_and8", 32'(bus8.and_out), 32'h00);
    check_val("rst_not8", 32'(bus8.not_out), 32'h00);
    check_val("rst_valid8", 32'(bus8.out_valid), 32'd0);
    rst = 1'b0;

    // Truth table, back-to-back with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      bus1.in_valid = 1'b1;
      bus1.a = 1'((i >> 1) & 1);
      bus1.b = 1'(i & 1);
      tick();
      check_val($sformatf("tt%0d_valid", i), 32'(bus1.out_valid), 32'd1);
      check_val($sformatf("tt%0d_and", i), 32'(bus1.and_out), 32'(tt_exp[i][3]));
      check_val($sformatf("tt%0d_or", i),  32'(bus1.or_out),  32'(tt_exp[i][2]));
      check_val($sformatf("tt%0d_xor", i), 32'(bus1.xor_out), 32'(tt_exp[i][1]));
      check_val($sformatf("tt%0d_not", i), 32'(bus1.not_out), 32'(tt_exp[i][0]));
    end

`ifdef BASIC_GATE_INV_EN
    bus1.a = 1'b1; bus1.b = 1'b0;
    tick();
    check_val("inv_nand", 32'(bus1.nand_out), 32'd1);
    check_val("inv_nor",  32'(bus1.nor_out),  32'd0);
    check_val("inv_xnor", 32'(bus1.xnor_out), 32'd0);
`endif

    // Reset wins over a same-cycle accept.
    bus1.a = 1'b1; bus1.b = 1'b1;
    tick();
    check_val("pre_rst_and", 32'(bus1.and_out), 32'd1);
    rst = 1'b1;
    tick();
    check_val("rst2_valid", 32'(bus1.out_valid), 32'd0);
    check_val("rst2_and", 32'(bus1.and_out), 32'd0);
    check_val("rst2_or",  32'(bus1.or_out),  32'd0);
    check_val("rst2_xor", 32'(bus1.xor_out), 32'd0);
    check_val("rst2_not", 32'(bus1.not_out), 32'd0);
    check_val("rst2_ready", 32'(bus1.in_ready), 32'd1);
    rst = 1'b0;
    bus1.in_valid = 1'b0;

    // Backpressure: result must hold and new operands must be refused.
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.a = 8'hF0; bus8.b = 8'h3C;
    tick();
    bus8.a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("bp%0d_valid", i), 32'(bus8.out_valid), 32'd1);
      check_val($sformatf("bp%0d_ready", i), 32'(bus8.in_ready), 32'd0);
      check_val($sformatf("bp%0d_and", i), 32'(bus8.and_out), 32'h30);
      check_val($sformatf("bp%0d_or", i),  32'(bus8.or_out),  32'hFC);
      check_val($sformatf("bp%0d_xor", i), 32'(bus8.xor_out), 32'hCC);
      check_val($sformatf("bp%0d_not", i), 32'(bus8.not_out), 32'h0F);
      tick();
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    check_val("bp_release_valid", 32'(bus8.out_valid), 32'd0);
    check_val("bp_release_and", 32'(bus8.and_out), 32'h30);

    // Full throughput: one accept and one result per cycle.
    for (int i = 0; i < 4; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a = tp_a[i];
      bus8.b = tp_b[i];
      tick();
      check_val($sformatf("tp%0d_valid", i), 32'(bus8.out_valid), 32'd1);
      check_val($sformatf("tp%0d_ready", i), 32'(bus8.in_ready), 32'd1);
      check_val($sformatf("tp%0d_and", i), 32'(bus8.and_out), 32'(tp_and[i]));
      check_val($sformatf("tp%0d_or", i),  32'(bus8.or_out),  32'(tp_or[i]));
      check_val($sformatf("tp%0d_xor", i), 32'(bus8.xor_out), 32'(tp_xor[i]));
      check_val($sformatf("tp%0d_not", i), 32'(bus8.not_out), 32'(tp_not[i]));
    end

    // Drain: valid drops, last result stays visible.
    bus8.in_valid = 1'b0;
    bus8.a = 8'h00; bus8.b = 8'h00;
    tick();
    check_val("drain_valid", 32'(bus8.out_valid), 32'd0);
    check_val("drain_ready", 32'(bus8.in_ready), 32'd1);
    check_val("drain_and", 32'(bus8.and_out), 32'h81);
    check_val("drain_or",  32'(bus8.or_out),  32'hC3);
    check_val("drain_xor", 32'(bus8.xor_out), 32'h42);
    check_val("drain_not", 32'(bus8.not_out), 32'h3C);
    tick();
    check_val("idle_valid", 32'(bus8.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
